// File: rtl/uart_cmd_pkg.sv
// Shared protocol constants and FSM state encoding for the UART command responder.
package uart_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        DHI,
        DLO,
        WRITE,
        READ,
        RWAIT,
        TX_HI,
        TX_LO,
        TX1
    } state_t;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: loadable down-counter; expired flags the last idle cycle allowed.
module uart_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 4800000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = LOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter at zero means TIMEOUT_CYCLES-1 idle cycles have already elapsed.
    assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses fixed-length W/R register commands from the host byte stream, drives the
// register bus and returns K / read data / ? replies on the device-to-host stream.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4800000,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 16
) (
    input  logic              clk_48mhz,
    input  logic              reset,
    input  logic [7:0]        uart_out_data,
    input  logic              uart_out_valid,
    output logic              uart_out_ready,
    output logic [7:0]        uart_in_data,
    output logic              uart_in_valid,
    input  logic              uart_in_ready,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy
);

    state_t            state_q, state_d;
    logic              op_rd_q, op_rd_d;
    logic              out_ready_q, out_ready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic rx_fire, tx_fire, wait_st, tmo_expired;

    assign rx_fire = uart_out_valid && out_ready_q;
    assign tx_fire = uart_in_valid && uart_in_ready;
    assign wait_st = (state_q == ADDR) || (state_q == DHI) || (state_q == DLO);

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk_48mhz),
        .rst    (reset),
        .clr    (rx_fire || !wait_st),
        .en     (wait_st && !rx_fire),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        op_rd_d = op_rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: if (rx_fire) begin
                if (uart_out_data == OP_WRITE) begin
                    op_rd_d = 1'b0;
                    state_d = ADDR;
                end else if (uart_out_data == OP_READ) begin
                    op_rd_d = 1'b1;
                    state_d = ADDR;
                end else begin
                    hold_d  = DATA_W'(RSP_ERR);
                    state_d = TX1;
                end
            end
            ADDR: if (rx_fire) begin
                addr_d  = ADDR_W'(uart_out_data);
                state_d = op_rd_q ? READ : DHI;
            end else if (tmo_expired) begin
                state_d = IDLE;
            end
            DHI: if (rx_fire) begin
                wdata_d[15:8] = uart_out_data;
                state_d       = DLO;
            end else if (tmo_expired) begin
                state_d = IDLE;
            end
            DLO: if (rx_fire) begin
                wdata_d[7:0] = uart_out_data;
                state_d      = WRITE;
            end else if (tmo_expired) begin
                state_d = IDLE;
            end
            WRITE: begin
                hold_d  = DATA_W'(RSP_ACK);
                state_d = TX1;
            end
            READ:  state_d = RWAIT;
            RWAIT: begin
                hold_d  = reg_rdata;
                state_d = TX_HI;
            end
            TX_HI: if (tx_fire) state_d = TX_LO;
            TX_LO: if (tx_fire) state_d = IDLE;
            TX1:   if (tx_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Registered ready follows the next state, so it falls right after the last byte.
        out_ready_d = (state_d == IDLE) || (state_d == ADDR) ||
                      (state_d == DHI)  || (state_d == DLO);
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_rd_q     <= 1'b0;
            out_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_rd_q     <= op_rd_d;
            out_ready_q <= out_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        uart_in_data = 8'h00;
        unique case (state_q)
            TX_HI:     uart_in_data = hold_q[15:8];
            TX_LO,
            TX1:       uart_in_data = hold_q[7:0];
            default:   uart_in_data = 8'h00;
        endcase
    end

    assign uart_out_ready = out_ready_q;
    assign uart_in_valid  = (state_q == TX_HI) || (state_q == TX_LO) || (state_q == TX1);
    assign reg_addr       = addr_q;
    assign reg_wdata      = wdata_q;
    assign reg_we         = (state_q == WRITE);
    assign reg_re         = (state_q == READ);
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Randomized bench for uart_cmd_responder against a command-level reference model.
module tb_uart_cmd_responder;

    localparam int TMO = 16;

    logic        clk_48mhz = 1'b0;
    logic        reset     = 1'b1;
    logic [7:0]  uart_out_data = 8'h00;
    logic        uart_out_valid = 1'b0;
    logic        uart_out_ready;
    logic [7:0]  uart_in_data;
    logic        uart_in_valid;
    logic        uart_in_ready = 1'b1;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we, reg_re;
    logic [15:0] reg_rdata;
    logic        busy;

    always #5 clk_48mhz = ~clk_48mhz;

    uart_cmd_responder #(
        .TIMEOUT_CYCLES(TMO),
        .ADDR_W(8),
        .DATA_W(16)
    ) dut (
        .clk_48mhz     (clk_48mhz),
        .reset         (reset),
        .uart_out_data (uart_out_data),
        .uart_out_valid(uart_out_valid),
        .uart_out_ready(uart_out_ready),
        .uart_in_data  (uart_in_data),
        .uart_in_valid (uart_in_valid),
        .uart_in_ready (uart_in_ready),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_we        (reg_we),
        .reg_re        (reg_re),
        .reg_rdata     (reg_rdata),
        .busy          (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Register file seen by the DUT, plus observation queues.
    logic [15:0] mem [256];
    logic [7:0]  tx_q [$];
    logic [23:0] wr_q [$];
    int          rd_cnt = 0;
    int          both_cnt = 0;
    logic        re_seen = 1'b0;
    logic [7:0]  re_addr = 8'h00;

    always @(negedge clk_48mhz) begin
        re_seen = reg_re;
        re_addr = reg_addr;
        if (reg_re && reg_we) both_cnt++;
        if (reg_re) rd_cnt++;
        if (reg_we) begin
            mem[reg_addr] = reg_wdata;
            wr_q.push_back({reg_addr, reg_wdata});
        end
        if (uart_in_valid && uart_in_ready) tx_q.push_back(uart_in_data);
    end

    // Read data is valid only the cycle after reg_re; garbage otherwise.
    always @(posedge clk_48mhz) reg_rdata <= re_seen ? mem[re_addr] : 16'($urandom);

    // Reference model: intended register contents and expected traffic.
    logic [15:0] mdl [256];
    logic [7:0]  exp_tx [$];
    logic [23:0] exp_wr [$];
    int          exp_rd = 0;

    task automatic send(input logic [7:0] b);
        int k;
        k = 0;
        uart_out_data  = b;
        uart_out_valid = 1'b1;
        @(negedge clk_48mhz);
        while (!uart_out_ready && k < 200) begin
            @(negedge clk_48mhz);
            k++;
        end
        chk("rx_accepted", {31'd0, uart_out_ready}, 32'd1);
        @(posedge clk_48mhz);
        #1;
        uart_out_valid = 1'b0;
    endtask

    task automatic do_cmd(input int kind, input logic [7:0] a, input logic [15:0] d,
                          input logic [7:0] ub);
        case (kind)
            0: begin
                send(8'h57); send(a); send(d[15:8]); send(d[7:0]);
                exp_tx.push_back(8'h4B);
                exp_wr.push_back({a, d});
                mdl[a] = d;
            end
            1: begin
                send(8'h52); send(a);
                exp_tx.push_back(mdl[a][15:8]);
                exp_tx.push_back(mdl[a][7:0]);
                exp_rd++;
            end
            default: begin
                send(ub);
                exp_tx.push_back(8'h3F);
            end
        endcase
    endtask

    task automatic drain(input bit rnd);
        int k;
        k = 0;
        if (!rnd) uart_in_ready = 1'b1;
        while ((tx_q.size() < exp_tx.size() || busy) && k < 500) begin
            if (rnd) uart_in_ready = 1'($urandom_range(0, 1));
            @(posedge clk_48mhz);
            #1;
            k++;
        end
        uart_in_ready = 1'b1;
        chk("tx_count", tx_q.size(), exp_tx.size());
        chk("wr_count", wr_q.size(), exp_wr.size());
        while (tx_q.size() > 0 && exp_tx.size() > 0) chk("tx_byte", tx_q.pop_front(), exp_tx.pop_front());
        while (wr_q.size() > 0 && exp_wr.size() > 0) chk("wr_txn", wr_q.pop_front(), exp_wr.pop_front());
        tx_q.delete(); wr_q.delete(); exp_tx.delete(); exp_wr.delete();
    endtask

    task automatic latency(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        do begin
            @(negedge clk_48mhz);
            lat++;
        end while (!uart_in_valid && lat < 20);
        chk(tag, lat, exp_lat);
    endtask

    initial begin
        int r0, bad, hi_cnt;
        logic [7:0]  ub;
        logic [15:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            mem[i] = v;
            mdl[i] = v;
        end
        mem[7] = 16'hABCD;
        mdl[7] = 16'hABCD;

        repeat (3) @(negedge clk_48mhz);
        chk("rst_ctl", {27'd0, uart_out_ready, uart_in_valid, reg_we, reg_re, busy}, 32'd0);
        chk("rst_data", {uart_in_data, reg_addr, reg_wdata}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk_48mhz);
        #1;

        // Write: reply 2 cycles after last byte, ready drops immediately.
        do_cmd(0, 8'h03, 16'h1234, 8'h00);
        chk("rdy_drop", {31'd0, uart_out_ready}, 32'd0);
        latency("wr_latency", 2);
        drain(0);
        chk("wr_busy_idle", {31'd0, busy}, 32'd0);
        chk("addr_hold", {24'd0, reg_addr}, 32'h03);
        chk("wdata_hold", {16'd0, reg_wdata}, 32'h1234);

        // Read: 3 cycles of latency, one reg_re pulse.
        r0 = rd_cnt;
        do_cmd(1, 8'h07, 16'h0, 8'h00);
        latency("rd_latency", 3);
        drain(0);
        chk("rd_pulses", rd_cnt - r0, 1);

        // Unknown opcode, then a normal read.
        do_cmd(2, 8'h00, 16'h0, 8'h00);
        drain(0);
        do_cmd(1, 8'h01, 16'h0, 8'h00);
        drain(0);

        // Address 0xFF behaves like any other.
        do_cmd(0, 8'hFF, 16'hBEEF, 8'h00);
        drain(0);
        do_cmd(1, 8'hFF, 16'h0, 8'h00);
        drain(0);

        // Backpressure: hi byte held, no rx accepted.
        uart_in_ready = 1'b0;
        do_cmd(1, 8'h20, 16'h0, 8'h00);
        bad = 0;
        for (int i = 0; i < 30 && !uart_in_valid; i++) @(negedge clk_48mhz);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_48mhz);
            if (!uart_in_valid || uart_in_data !== mdl[8'h20][15:8] || uart_out_ready) bad++;
        end
        chk("bp_hold_bad", bad, 0);
        drain(0);

        // Timeout: 16 silent cycles abandon the command with no side effects.
        send(8'h57); send(8'h05);
        hi_cnt = 0;
        repeat (16) begin
            @(negedge clk_48mhz);
            if (busy) hi_cnt++;
        end
        chk("tmo_busy_cycles", hi_cnt, 16);
        @(negedge clk_48mhz);
        chk("tmo_idle", {31'd0, busy}, 32'd0);
        repeat (4) @(posedge clk_48mhz);
        #1;
        chk("tmo_no_tx", tx_q.size(), 0);
        chk("tmo_no_wr", wr_q.size(), 0);
        do_cmd(1, 8'h05, 16'h0, 8'h00);
        drain(0);

        // A byte landing on the expiry cycle is still accepted.
        send(8'h57); send(8'h09);
        repeat (15) @(posedge clk_48mhz);
        #1;
        send(8'h12); send(8'h34);
        exp_tx.push_back(8'h4B);
        exp_wr.push_back({8'h09, 16'h1234});
        mdl[9] = 16'h1234;
        drain(0);
        do_cmd(1, 8'h09, 16'h0, 8'h00);
        drain(0);

        // Randomized commands with random reply backpressure.
        for (int n = 0; n < 40; n++) begin
            do ub = 8'($urandom); while (ub == 8'h57 || ub == 8'h52);
            do_cmd($urandom_range(0, 2), 8'($urandom), 16'($urandom), ub);
            drain(1);
        end

        // Reset while the hi reply byte is stalled.
        uart_in_ready = 1'b0;
        send(8'h52); send(8'h30);
        exp_rd++;
        for (int i = 0; i < 30 && !uart_in_valid; i++) @(negedge clk_48mhz);
        repeat (3) @(negedge clk_48mhz);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_ctl", {27'd0, uart_out_ready, uart_in_valid, reg_we, reg_re, busy}, 32'd0);
        chk("rst_mid_data", {uart_in_data, reg_addr, reg_wdata}, 32'd0);
        @(negedge clk_48mhz);
        reset = 1'b0;
        uart_in_ready = 1'b1;
        repeat (10) @(posedge clk_48mhz);
        #1;
        chk("rst_no_tx", tx_q.size(), 0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        chk("we_re_both", both_cnt, 0);
        chk("rd_total", rd_cnt, exp_rd);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Device-side endpoint of the USB-UART byte pipelines.
- Consumes host-to-device bytes (uart_out_*), parses fixed-length register commands, drives a simple register bus, and returns replies on the device-to-host pipeline (uart_in_*).
- Sits between the USB UART wrapper and the array-driver register file (phase/amplitude/control registers).

Parameters:
- TIMEOUT_CYCLES, 4800000, idle cycles allowed between bytes of one command before abort (100 ms at 48 MHz).
- ADDR_W, 8, register address width.
- DATA_W, 16, register data width; fixed at 16 for this protocol.

Ports:
- clk_48mhz  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- uart_out_data  input  8  byte from host.
- uart_out_valid  input  1  host byte valid.
- uart_out_ready  output  1  responder accepts byte.
- uart_in_data  output  8  reply byte to host.
- uart_in_valid  output  1  reply byte valid.
- uart_in_ready  input  1  USB side accepts reply byte.
- reg_addr  output  ADDR_W  register address.
- reg_wdata  output  DATA_W  write data.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read strobe.
- reg_rdata  input  DATA_W  read data, valid exactly 1 cycle after reg_re.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: uart_out_ready=0, uart_in_valid=0, uart_in_data=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0. The FSM resets to IDLE and the timeout counter clears.
- An rx byte transfers on uart_out_valid&&uart_out_ready. A tx byte transfers on uart_in_valid&&uart_in_ready.
- uart_out_ready=1 only in IDLE, ADDR, DHI, DLO. It is registered and drops the cycle after the final byte of a command is accepted.
- Once uart_in_valid is asserted, it and uart_in_data stay stable until the transfer occurs.
- Opcodes: W=0x57 (write: W, addr, data_hi, data_lo; reply 0x4B 'K'). R=0x52 (read: R, addr; reply rdata[15:8] then rdata[7:0]). Any other byte in IDLE gets reply 0x3F '?'.
- States and transitions:
  - IDLE: W goes to ADDR (op=W). R goes to ADDR (op=R). Other byte goes to TX1 with byte 0x3F.
  - ADDR: latch reg_addr. op=W goes to DHI; op=R goes to READ.
  - DHI: latch reg_wdata[15:8], go to DLO.
  - DLO: latch reg_wdata[7:0], go to WRITE.
  - WRITE: reg_we=1 for exactly one cycle, then TX1 with byte 0x4B.
  - READ: reg_re=1 for one cycle, then RWAIT.
  - RWAIT: capture reg_rdata into a 16-bit hold register, then TX_HI.
  - TX_HI: present hold[15:8]; on transfer go to TX_LO.
  - TX_LO: present hold[7:0]; on transfer go to IDLE.
  - TX1: present the single reply byte; on transfer go to IDLE.
- Latency, zero backpressure: last command byte accepted at cycle N gives the first reply byte valid at N+2 (write) or N+3 (read).
- Timeout:
  - The counter runs only in ADDR, DHI, DLO while no byte transfers.
  - It clears on every accepted byte and on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE silently: no reply, no reg strobe.
  - A byte arriving in the same cycle as expiry is accepted, and the timeout is ignored.
- No timeout in TX states: the responder waits for uart_in_ready indefinitely and accepts no rx bytes meanwhile.
- reg_addr and reg_wdata hold their last values between commands. reg_we and reg_re are never high together.
- Address 0xFF is an ordinary address; there is no wrap or special case.
- Asynchronous reset mid-command or mid-reply aborts immediately to reset values; a partial reply is never resumed.

Decomposition:
- Package uart_cmd_pkg holds:
  - opcode constants OP_WRITE=8'h57, OP_READ=8'h52;
  - reply constants RSP_ACK=8'h4B, RSP_ERR=8'h3F;
  - the FSM state enum (IDLE, ADDR, DHI, DLO, WRITE, READ, RWAIT, TX_HI, TX_LO, TX1).
- One natural sub-module: uart_cmd_timeout. It is a loadable down-counter with clear/enable/expired, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write: rx 57,03,12,34 back-to-back, uart_in_ready=1. Expect reg_we pulses once with reg_addr=03, reg_wdata=1234, then tx 4B, then busy=0.
- Read: rx 52,07 with reg_rdata=ABCD one cycle after reg_re. Expect tx AB then CD, and a single reg_re pulse.
- Unknown: rx 00 in IDLE. Expect tx 3F, no strobes. A following 52,01 then reads normally.
- Backpressure: read with uart_in_ready=0 for 20 cycles. Expect uart_in_valid=1 and data=hi byte held stable, uart_out_ready=0 throughout, and both bytes delivered after release.
- Timeout (TIMEOUT_CYCLES=16): rx 57,05, then silence for 16 cycles. Expect return to IDLE with no reg_we and no tx. The next 52,05 reads normally.
- Reset mid-reply: assert reset while TX_HI is stalled. Expect all outputs at reset values in the same cycle, and no residual tx byte after reset release.
